// File: rtl/apb_modport_slave_pkg.sv
// apb_pkg: shared state encoding and default sizing for the APB register slave.
package apb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_DEPTH = 256;
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    ERROR_ACCESS = 2'b01,
    WRITE_ACCESS = 2'b10,
    READ_ACCESS  = 2'b11
  } apb_state_e;
endpackage

// File: rtl/apb_modport_slave_if.sv
// apb_if: APB3 bus bundle with requester (master) and completer (slave) views.
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata, pslverr);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_modport_slave_mem.sv
// apb_slave_mem: register array with one synchronous write port, one combinational read port and async clear.
module apb_slave_mem #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/apb_modport_slave.sv
// apb_modport_slave: zero-wait-state APB3 completer over a DEPTH-word register memory,
// answering out-of-range word addresses with pslverr.
import apb_pkg::*;
module apb_modport_slave #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int DEPTH      = MEM_DEPTH
) (
  input logic pclk,
  input logic rst_n,
  apb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  apb_state_e            state, state_nxt;
  logic                  setup, access, in_range, we;
  logic [DATA_WIDTH-1:0] rdata;
  assign setup    = bus.psel & ~bus.penable;
  assign access   = bus.psel & bus.penable;
  // full-width compare: no aliasing of high address bits onto the array
  assign in_range = bus.paddr < ADDR_WIDTH'(DEPTH);
  assign we       = (state == WRITE_ACCESS) & access & in_range;
  always_comb
    state_nxt = !setup ? IDLE : !in_range ? ERROR_ACCESS : bus.pwrite ? WRITE_ACCESS : READ_ACCESS;
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // prdata only moves on a valid read setup, so errors and writes leave it untouched
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) bus.prdata <= '0;
    else if (setup && in_range && !bus.pwrite) bus.prdata <= rdata;
  assign bus.pready  = (state != IDLE) & access;
  assign bus.pslverr = (state == ERROR_ACCESS) & access;
  apb_slave_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_mem (
    .pclk  (pclk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (bus.paddr[AW-1:0]),
    .wdata (bus.pwdata),
    .raddr (bus.paddr[AW-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_apb_modport_slave.sv
// tb_apb_modport_slave: directed APB transfers with a scoreboard queue of expected access-phase responses.
module tb_apb_modport_slave;
  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic        is_rd;
  } exp_t;
  logic        pclk = 0;
  logic        rst_n = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] model [256];
  logic [31:0] last_rd = 0;
  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb_modport_slave dut (.pclk(pclk), .rst_n(rst_n), .bus(bus.slave));
  always #5 pclk = ~pclk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0;
  endtask
  task automatic xfer(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic err;
    err = a >= 32'd256;
    e.err = err;
    e.is_rd = !wr;
    e.data = (wr || err) ? last_rd : model[a[7:0]];
    sb.push_back(e);
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    check({tag, "_setup_rdy"}, {31'b0, bus.pready}, 0);
    check({tag, "_setup_err"}, {31'b0, bus.pslverr}, 0);
    @(posedge pclk); #1;
    bus.penable = 1;
    #1;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdy"}, {31'b0, bus.pready}, 1);
      check({tag, "_err"}, {31'b0, bus.pslverr}, {31'b0, e.err});
      check({tag, "_prdata"}, bus.prdata, e.data);
      if (wr && !err) model[a[7:0]] = d;
      if (!wr && !err) last_rd = e.data;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) model[i] = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_rdy", {31'b0, bus.pready}, 0);
    check("rst_prdata", bus.prdata, 0);
    rst_n = 1;
    xfer("w5", 1, 5, 32'h0000_0055);
    xfer("r5", 0, 5, 0);
    // reset in the access phase of a write: outputs drop at once, write is lost
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 5; bus.pwdata = 32'h0BAD_0BAD;
    @(posedge pclk); #1;
    bus.penable = 1;
    #1;
    check("mid_rdy_before", {31'b0, bus.pready}, 1);
    rst_n = 0;
    #1;
    check("mid_rst_rdy", {31'b0, bus.pready}, 0);
    check("mid_rst_err", {31'b0, bus.pslverr}, 0);
    check("mid_rst_prdata", bus.prdata, 0);
    bus.psel = 0; bus.penable = 0;
    @(posedge pclk); #1;
    rst_n = 1;
    for (int i = 0; i < 256; i++) model[i] = 0;
    last_rd = 0;
    xfer("r5_after_rst", 0, 5, 0);
    check("r5_after_rst_val", bus.prdata, 0);
    idle();
    xfer("w10", 1, 10, 32'hDEAD_BEEF);
    xfer("r10", 0, 10, 0);
    check("r10_val", bus.prdata, 32'hDEAD_BEEF);
    idle();
    xfer("w255", 1, 255, 32'h1234_5678);
    xfer("r255", 0, 255, 0);
    check("r255_val", bus.prdata, 32'h1234_5678);
    xfer("w256", 1, 256, 32'hCAFE_F00D);
    xfer("r0", 0, 0, 0);
    check("r0_val", bus.prdata, 0);
    idle();
    xfer("w20", 1, 20, 32'hA5A5_A5A5);
    xfer("r20", 0, 20, 0);
    xfer("r1000", 0, 32'h0000_1000, 0);
    check("r1000_hold", bus.prdata, 32'hA5A5_A5A5);
    xfer("rffff", 0, 32'hFFFF_FFFF, 0);
    xfer("wffff", 1, 32'hFFFF_FFFF, 32'h7777_7777);
    xfer("r255_noalias", 0, 255, 0);
    check("r255_noalias_val", bus.prdata, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      xfer($sformatf("b2b_w%0d", i), 1, i, 32'h1000_0000 + 32'(i) * 32'h0101_0101);
      xfer($sformatf("b2b_r%0d", i), 0, i, 0);
    end
    // write to 7 abandoned during its access phase
    @(posedge pclk); #1;
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 7; bus.pwdata = 32'hFFFF_FFFF;
    check("abort_setup_rdy", {31'b0, bus.pready}, 0);
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 1;
    #1;
    check("abort_access_rdy", {31'b0, bus.pready}, 0);
    idle();
    xfer("r7", 0, 7, 0);
    check("r7_val", bus.prdata, 0);
    idle();
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
